// File: rtl/npu_pkg.sv
// Shared NPU front-end types: scan-controller state encoding and pixel address helper.
package npu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      PUSH,
      WAIT,
      DONE
   } wsc_state_t;

   localparam int unsigned NPU_ADDR_W = 16;

   // Row-major linear pixel address, computed at full width before trimming.
   function automatic logic [NPU_ADDR_W-1:0] pix_addr(input logic [31:0] row,
                                                      input logic [31:0] col,
                                                      input logic [31:0] width);
      return NPU_ADDR_W'(row * width + col);
   endfunction

endpackage

// File: rtl/window_scan_ctrl.sv
// 3-row line-buffer scan sequencer: walks an IMG_W x IMG_H image and hands 3x3 windows downstream.
// Optional horizontal zero padding is enabled by defining WINDOW_SCAN_ZERO_PAD_EN.
module window_scan_ctrl
   import npu_pkg::*;
#(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int ADDR_W = NPU_ADDR_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_addr_r1,
   output logic [ADDR_W-1:0]          mem_addr_r2,
   output logic [ADDR_W-1:0]          mem_addr_r3,
   output logic                       lb_wr_en,
   output logic                       lb_shift,
   output logic                       pad_zero,
   output logic                       win_valid,
   input  logic                       win_ready,
   output logic [$clog2(IMG_H)-1:0]   win_row,
   output logic [$clog2(IMG_W)-1:0]   win_col
);

   localparam int unsigned CW  = $clog2(IMG_W + 2);
   localparam int unsigned RW  = $clog2(IMG_H);
   localparam int unsigned WCW = $clog2(IMG_W);
`ifdef WINDOW_SCAN_ZERO_PAD_EN
   localparam int unsigned LAST_C = IMG_W + 1;
`else
   localparam int unsigned LAST_C = IMG_W - 1;
`endif
   localparam logic [CW-1:0] C_LAST = CW'(LAST_C);
   localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 3);

   wsc_state_t      r_state, w_state_nxt;
   logic [RW-1:0]   r_row,   w_row_nxt;
   logic [CW-1:0]   r_col,   w_col_nxt;
   logic [1:0]      r_fill,  w_fill_nxt;
   logic [1:0]      w_fill_inc;
   logic            w_pad_step;
   logic [31:0]     w_mem_col;

`ifdef WINDOW_SCAN_ZERO_PAD_EN
   // Push positions 0 and IMG_W+1 are the pad columns; memory column lags push index by one.
   assign w_pad_step = (r_col == '0) || (r_col == C_LAST);
   assign w_mem_col  = 32'(r_col) - 32'd1;
`else
   assign w_pad_step = 1'b0;
   assign w_mem_col  = 32'(r_col);
`endif

   assign w_fill_inc = (r_fill == 2'd3) ? 2'd3 : r_fill + 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_fill  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
         r_fill  <= w_fill_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_fill_nxt  = r_fill;
      busy        = 1'b0;
      done        = 1'b0;
      mem_rd_en   = 1'b0;
      mem_addr_r1 = '0;
      mem_addr_r2 = '0;
      mem_addr_r3 = '0;
      lb_wr_en    = 1'b0;
      lb_shift    = 1'b0;
      pad_zero    = 1'b0;
      win_valid   = 1'b0;
      win_row     = '0;
      win_col     = '0;
      case (r_state)
         IDLE: begin
            w_row_nxt  = '0;
            w_col_nxt  = '0;
            w_fill_nxt = '0;
            if (start) w_state_nxt = READ;
         end
         READ: begin
            busy      = 1'b1;
            mem_rd_en = !w_pad_step;
            if (!w_pad_step) begin
               mem_addr_r1 = ADDR_W'(pix_addr(32'(r_row),         w_mem_col, 32'(IMG_W)));
               mem_addr_r2 = ADDR_W'(pix_addr(32'(r_row) + 32'd1, w_mem_col, 32'(IMG_W)));
               mem_addr_r3 = ADDR_W'(pix_addr(32'(r_row) + 32'd2, w_mem_col, 32'(IMG_W)));
            end
            w_state_nxt = PUSH;
         end
         PUSH: begin
            busy       = 1'b1;
            lb_wr_en   = 1'b1;
            lb_shift   = 1'b1;
            pad_zero   = w_pad_step;
            w_fill_nxt = w_fill_inc;
            if (w_fill_inc == 2'd3) begin
               w_state_nxt = WAIT;
            end else begin
               w_col_nxt   = r_col + CW'(1);
               w_state_nxt = READ;
            end
         end
         WAIT: begin
            busy      = 1'b1;
            win_valid = 1'b1;
            win_row   = r_row;
            win_col   = WCW'(r_col - CW'(2));
            if (win_ready) begin
               if (r_col != C_LAST) begin
                  w_col_nxt   = r_col + CW'(1);
                  w_state_nxt = READ;
               end else if (r_row != R_LAST) begin
                  w_row_nxt   = r_row + RW'(1);
                  w_col_nxt   = '0;
                  w_fill_nxt  = '0;
                  w_state_nxt = READ;
               end else begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed self-checking bench for window_scan_ctrl (4x3 and 3x4 images).
module tb_window_scan_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_start = 1'b0;
   logic b_start = 1'b0;
   logic rdy = 1'b0;

   logic a_busy, a_done, a_rd, a_wr, a_shift, a_pad, a_valid;
   logic [15:0] a_a1, a_a2, a_a3;
   logic [1:0]  a_row, a_col;
   logic b_busy, b_done, b_rd, b_wr, b_shift, b_pad, b_valid;
   logic [15:0] b_a1, b_a2, b_a3;
   logic [1:0]  b_row, b_col;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   window_scan_ctrl #(.IMG_W(4), .IMG_H(3), .ADDR_W(16)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
      .mem_rd_en(a_rd), .mem_addr_r1(a_a1), .mem_addr_r2(a_a2), .mem_addr_r3(a_a3),
      .lb_wr_en(a_wr), .lb_shift(a_shift), .pad_zero(a_pad), .win_valid(a_valid),
      .win_ready(rdy), .win_row(a_row), .win_col(a_col)
   );

   window_scan_ctrl #(.IMG_W(3), .IMG_H(4), .ADDR_W(16)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
      .mem_rd_en(b_rd), .mem_addr_r1(b_a1), .mem_addr_r2(b_a2), .mem_addr_r3(b_a3),
      .lb_wr_en(b_wr), .lb_shift(b_shift), .pad_zero(b_pad), .win_valid(b_valid),
      .win_ready(rdy), .win_row(b_row), .win_col(b_col)
   );

   logic [58:0] a_vec, b_vec;
   assign a_vec = {a_busy, a_done, a_rd, a_wr, a_shift, a_pad, a_valid, a_row, a_col, a_a1, a_a2, a_a3};
   assign b_vec = {b_busy, b_done, b_rd, b_wr, b_shift, b_pad, b_valid, b_row, b_col, b_a1, b_a2, b_a3};

   typedef struct {
      logic        start;
      logic        rdy;
      logic        busy;
      logic        done;
      logic        rd;
      logic        wr;
      logic        valid;
      logic [1:0]  col;
      logic [15:0] a1;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected dut_a output vector for a 4-wide image, row 0 (r2/r3 one and two rows below r1).
   function automatic logic [58:0] exp_a(input vec_t v);
      logic [15:0] e2, e3;
      e2 = v.rd ? v.a1 + 16'd4 : 16'd0;
      e3 = v.rd ? v.a1 + 16'd8 : 16'd0;
      return {v.busy, v.done, v.rd, v.wr, v.wr, 1'b0, v.valid, 2'b00, v.col, v.a1, e2, e3};
   endfunction

   // Runs dut_a to its done pulse, counting accepted windows including the current cycle.
   task automatic run_a_to_done(input string name, output int wins);
      bit seen;
      seen = 1'b0;
      wins = 0;
      for (int i = 0; i < 100; i++) begin
         if (a_valid && rdy) wins++;
         if (a_done) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_a_valid(input string name, output int cycles);
      cycles = 0;
      while (!a_valid && cycles < 50) begin
         tick();
         a_start = 1'b0;
         cycles++;
      end
      if (!a_valid) check({name, "_timeout"}, 64'd0, 64'd1);
   endtask

`ifndef WINDOW_SCAN_ZERO_PAD_EN
   vec_t tbl[14];
`endif

   initial begin
      int wins;
      int cyc;
      #1;
      check("reset_a", 64'(a_vec), 64'd0);
      check("reset_b", 64'(b_vec), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

`ifndef WINDOW_SCAN_ZERO_PAD_EN
      //           start rdy busy done rd wr valid col a1
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd1};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd2};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'd0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd3};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'd0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0};

      for (int k = 0; k < 14; k++) begin
         a_start = tbl[k].start;
         rdy     = tbl[k].rdy;
         check($sformatf("scan4x3_cyc%0d", k), 64'(a_vec), 64'(exp_a(tbl[k])));
         tick();
      end
      a_start = 1'b0;

      // 3x4 image: row change with a 6-cycle refill.
      b_start = 1'b1;
      rdy = 1'b1;
      wins = 0;
      for (int k = 0; k < 17; k++) begin
         if (k == 7)  check("b_win0", 64'({b_valid, b_row, b_col}), 64'({1'b1, 2'd0, 2'd0}));
         if (k == 8)  check("b_row1_addr", 64'({b_rd, b_a1, b_a2, b_a3}), 64'({1'b1, 16'd3, 16'd6, 16'd9}));
         if (k >= 8 && k <= 13 && b_valid) wins += 100;
         if (k == 14) check("b_win1", 64'({b_valid, b_row, b_col}), 64'({1'b1, 2'd1, 2'd0}));
         if (k == 15) check("b_done", 64'({b_done, b_busy}), 64'({1'b1, 1'b0}));
         if (b_valid && rdy) wins++;
         tick();
         b_start = 1'b0;
      end
      check("b_window_count", 64'(wins), 64'd2);

      // Backpressure on the first window.
      a_start = 1'b1;
      rdy = 1'b0;
      tick();
      a_start = 1'b0;
      wait_a_valid("bp_first", cyc);
      check("bp_first_cycle", 64'(cyc), 64'd6);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp_stall%0d", i), 64'({a_valid, a_row, a_col, a_rd, a_wr}),
               64'({1'b1, 2'd0, 2'd0, 1'b0, 1'b0}));
      end
      rdy = 1'b1;
      run_a_to_done("bp", wins);
      check("bp_window_count", 64'(wins), 64'd2);
      tick();

      // Reset in the PUSH cycle of column 1.
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      tick();
      tick();
      tick();
      check("rst_pre_push", 64'({a_wr, a_valid}), 64'({1'b1, 1'b0}));
      rst = 1'b1;
      #1;
      check("rst_mid_scan", 64'(a_vec), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("rst_rescan_addr", 64'({a_rd, a_a1, a_a2, a_a3}), 64'({1'b1, 16'd0, 16'd4, 16'd8}));
      for (int i = 0; i < 6; i++) tick();
      check("rst_rescan_win", 64'({a_valid, a_row, a_col}), 64'({1'b1, 2'd0, 2'd0}));
      run_a_to_done("rst_rescan", wins);
      check("rst_rescan_count", 64'(wins), 64'd2);
      tick();

      // start pulsed during WAIT is ignored.
      a_start = 1'b1;
      rdy = 1'b0;
      tick();
      a_start = 1'b0;
      wait_a_valid("wait_start", cyc);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      rdy = 1'b1;
      run_a_to_done("wait_start", wins);
      check("wait_start_count", 64'(wins), 64'd2);
      tick();
      tick();
      check("wait_start_idle", 64'(a_vec), 64'd0);
      tick();
      check("wait_start_no_restart", 64'(a_vec), 64'd0);
`else
      begin
         int pushes;
         logic [5:0] pad_mask;
         pushes = 0;
         pad_mask = '0;
         wins = 0;
         a_start = 1'b1;
         rdy = 1'b1;
         tick();
         a_start = 1'b0;
         for (int i = 0; i < 60 && !a_done; i++) begin
            if (a_wr) begin
               check($sformatf("pad_shift%0d", pushes), 64'(a_shift), 64'd1);
               if (a_pad && pushes < 6) pad_mask[pushes] = 1'b1;
               pushes++;
            end
            if (a_busy && !a_rd && !a_wr && !a_valid && pushes % 6 == 0)
               check("pad_read_no_rd", 64'({a_a1, a_a2, a_a3}), 64'd0);
            if (a_valid && rdy) begin
               check($sformatf("pad_win%0d_col", wins), 64'({a_row, a_col}), 64'({2'd0, 2'(wins)}));
               wins++;
            end
            tick();
         end
         check("pad_done", 64'(a_done), 64'd1);
         check("pad_window_count", 64'(wins), 64'd4);
         check("pad_push_count", 64'(pushes), 64'd6);
         check("pad_zero_positions", 64'(pad_mask), 64'(6'b100001));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule
